seg7_scan: RTL

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a frame of BCD digits and selects one digit position at a time. It presents that digit's BCD code on `bcd_out`, which feeds `bcd_to_seg7` directly, and drives the matching active-low digit enable. A blanking interval at the start of every slot suppresses ghosting. Optional leading-zero suppression is provided, and displayed data changes only on frame boundaries to prevent tearing.

---
 rtl/seg7_scan.sv | 81 ++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Multi-digit 7-segment scan controller: per-slot blanking, frame-synchronous
// data commit, optional leading-zero suppression. All outputs registered.
module seg7_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic                          lz_blank,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         digit_sel_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [NUM_DIGITS-1:0][3:0] pending, pending_nx, active, active_nx;
  logic [NUM_DIGITS:0] lz_run;
  logic [NUM_DIGITS-1:0] sel_nx;
  logic [3:0] bcd_nx;
  logic slot_end, frame_end, lit;

  // Outputs are derived from next-state so the registered values line up
  // with the (idx, cnt) they describe.
  always_comb begin
    slot_end   = (cnt == LAST_CNT);
    frame_end  = slot_end && (idx == LAST_IDX);
    cnt_nx     = slot_end ? '0 : cnt + 1'b1;
    idx_nx     = !slot_end ? idx : (frame_end ? '0 : idx + 1'b1);
    pending_nx = load ? digits_in : pending;
    active_nx  = frame_end ? pending_nx : active;
    lit        = (cnt_nx >= CW'(BLANK_CYCLES));

    // lz_run[i] is set when digits i..NUM_DIGITS-1 are all zero
    lz_run = '0;
    lz_run[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      lz_run[i] = lz_run[i+1] && (active_nx[i] == 4'h0);

    sel_nx = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      sel_nx[i] = !(lit && (idx_nx == IW'(i)));

    if (!lit)
      bcd_nx = 4'hF;
    else if (lz_blank && (idx_nx != '0) && lz_run[idx_nx])
      bcd_nx = 4'hF;
    else
      bcd_nx = active_nx[idx_nx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= '0;
      active      <= '0;
      bcd_out     <= 4'hF;
      digit_sel_n <= '1;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      pending     <= pending_nx;
      active      <= active_nx;
      bcd_out     <= bcd_nx;
      digit_sel_n <= sel_nx;
      digit_idx   <= idx_nx;
      frame_start <= frame_end;
    end
  end
endmodule
